// File: rtl/core_dmem_resp.sv
// rtl/core_dmem_resp.sv - LSU data-memory responder with in-order load response queue
// Optional feature macro: DMEM_MISALIGN_CHK_EN (flag misaligned half/word accesses).
module core_dmem_resp #(
  parameter int AW         = 10,
  parameter int RESP_DEPTH = 4,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vld,
  input  logic        req_wen,
  input  logic [2:0]  req_rwtyp,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_rdy,
  output logic        resp_vld,
  output logic [31:0] resp_rdata,
  input  logic        resp_rdy,
  output logic        bus_err
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int WW = 4;
  localparam logic [PW-1:0] PTR_LAST  = PW'(RESP_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RESP_DEPTH);
  localparam logic [WW-1:0] WAIT_INIT = WW'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Control and queue state
  state_t        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_q, hold_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;

  // Storage arrays (never reset)
  logic [31:0]   mem_q  [2**AW];
  logic [31:0]   qmem_q [RESP_DEPTH];

  // Request decode
  logic          accept;
  logic          pop;
  logic          push;
  logic [31:0]   push_data;
  logic          typ_ok;
  logic          bad;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          wr_en;
  logic          unused_addr_hi;

  assign accept         = req_vld && req_rdy;
  assign pop            = resp_vld && resp_rdy;
  assign widx           = req_addr[AW+1:2];
  assign rword          = mem_q[widx];
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // Legal-type decode and effective lane offset (half/word force their low bits to zero)
  always_comb begin
    typ_ok = 1'b0;
    off    = req_addr[1:0];
    case (req_rwtyp)
      3'b000: typ_ok = 1'b1;
      3'b001: begin
        typ_ok = 1'b1;
        off    = {req_addr[1], 1'b0};
      end
      3'b010: begin
        typ_ok = 1'b1;
        off    = 2'b00;
      end
      3'b100: typ_ok = !req_wen;
      3'b101: begin
        typ_ok = !req_wen;
        off    = {req_addr[1], 1'b0};
      end
      default: typ_ok = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic mis;
  assign mis = ((req_rwtyp[1:0] == 2'b01) && req_addr[0]) ||
               ((req_rwtyp[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign bad = !typ_ok || mis;
`else
  assign bad = !typ_ok;
`endif

  // Load lane extraction and sign/zero extension; errored loads return zero
  always_comb begin
    ld_byte = 8'(rword >> {off, 3'b000});
    ld_half = off[1] ? rword[31:16] : rword[15:0];
    case (req_rwtyp)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rword;
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = '0;
    endcase
    if (bad) begin
      ld_data = '0;
    end
  end

  // Store byte enables and lane replication of the low store data
  always_comb begin
    case (req_rwtyp[1:0])
      2'b00: begin
        st_be   = 4'b0001 << off;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
    wr_en = accept && req_wen && !bad;
  end

  // Load sequencing: immediate push for single-cycle latency, else hold data through WAIT
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = ld_data;
    case (state_q)
      ST_IDLE: begin
        if (accept && !req_wen) begin
          if (LATENCY == 1) begin
            push = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
            hold_d  = ld_data;
          end
        end
      end
      ST_WAIT: begin
        cnt_d     = cnt_q - 1'b1;
        push_data = hold_q;
        if (cnt_d == '0) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointers, occupancy, next-cycle ready and sticky error
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    rdy_d   = (state_d == ST_IDLE) && (count_d < DEPTH_C);
    err_d   = err_q || (accept && bad);
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // SRAM byte writes and response queue writes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
    if (push) begin
      qmem_q[wptr_q] <= push_data;
    end
  end

  assign req_rdy    = rdy_q && rstn;
  assign resp_vld   = (count_q != '0);
  assign resp_rdata = resp_vld ? qmem_q[rptr_q] : '0;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// tb/tb_core_dmem_resp.sv - randomized self-checking bench for core_dmem_resp
`timescale 1ns/1ps
module tb_core_dmem_resp;

  localparam int DEPTH = 4;
  localparam int NDUT  = 3;
  int lat_tab [NDUT] = '{1, 3, 4};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_rwtyp = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_rdy = 1'b1;
  int          sel = 0;
  int          lat = 1;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, err0, err1, err2;
  logic [31:0] rd0, rd1, rd2;
  logic        req_rdy, resp_vld, bus_err;
  logic [31:0] resp_rdata;

  core_dmem_resp #(.AW(10), .RESP_DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld && sel == 0), .req_wen(req_wen),
    .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(rdy0),
    .resp_vld(vld0), .resp_rdata(rd0), .resp_rdy(resp_rdy), .bus_err(err0));
  core_dmem_resp #(.AW(10), .RESP_DEPTH(DEPTH), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld && sel == 1), .req_wen(req_wen),
    .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(rdy1),
    .resp_vld(vld1), .resp_rdata(rd1), .resp_rdy(resp_rdy), .bus_err(err1));
  core_dmem_resp #(.AW(10), .RESP_DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld && sel == 2), .req_wen(req_wen),
    .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(rdy2),
    .resp_vld(vld2), .resp_rdata(rd2), .resp_rdy(resp_rdy), .bus_err(err2));

  assign req_rdy    = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  assign resp_vld   = (sel == 0) ? vld0 : (sel == 1) ? vld1 : vld2;
  assign resp_rdata = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd2;
  assign bus_err    = (sel == 0) ? err0 : (sel == 1) ? err1 : err2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, dut %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  // Reference model: byte-addressed image of the 256-byte test region and a queue of expected beats
  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic [7:0]  mbyte [256];
  exp_t        expq [$];
  exp_t        ent;
  int          last_pop  = -100;
  int          last_load = -100;
  logic        err_m = 1'b0;
  int          n_acc = 0;
  int          n_resp = 0;
  logic [31:0] last_resp = 32'b0;
  logic        m_err;
  logic [31:0] m_data;
  logic        exp_vld, exp_rdy;
  int          t_ready;

  function automatic void model_req(input logic wen, input logic [2:0] typ, input logic [31:0] a,
                                    input logic [31:0] wd, output logic err, output logic [31:0] rd);
    bit legal;
    bit mis;
    int size;
    int base;
    int v;
    legal = wen ? (typ <= 3'd2) : (typ inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
    mis   = (int'(a[1:0]) % size) != 0;
`ifdef DMEM_MISALIGN_CHK_EN
    err = !legal || mis;
`else
    err = !legal;
`endif
    base = int'(a[7:0]);
    base = base - (base % size);
    rd = 32'b0;
    if (!err) begin
      if (wen) begin
        for (int k = 0; k < size; k++) mbyte[base + k] = 8'(wd >> (8 * k));
      end else begin
        v = 0;
        for (int k = 0; k < size; k++) v = v | (int'(mbyte[base + k]) << (8 * k));
        if (!typ[2] && size < 4 && v >= (1 << (8 * size - 1))) v = v - (1 << (8 * size));
        rd = 32'(v);
      end
    end
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Cycle monitor: compares handshake, data, latency and error flag against the model
  always @(negedge clk) begin
    if (!rstn) begin
      check_eq("rdy_in_reset", {31'b0, req_rdy}, 32'd0);
      expq.delete();
      err_m     = 1'b0;
      last_pop  = -100;
      last_load = -100;
    end else begin
      exp_rdy = (cyc >= last_load + lat) && (expq.size() < DEPTH);
      check_eq("req_rdy", {31'b0, req_rdy}, {31'b0, exp_rdy});
      check_eq("bus_err", {31'b0, bus_err}, {31'b0, err_m});
      exp_vld = 1'b0;
      if (expq.size() > 0) begin
        t_ready = expq[0].acc + lat;
        if (last_pop + 1 > t_ready) t_ready = last_pop + 1;
        exp_vld = (cyc >= t_ready);
      end
      check_eq("resp_vld", {31'b0, resp_vld}, {31'b0, exp_vld});
      if (resp_vld && exp_vld) check_eq("resp_rdata", resp_rdata, expq[0].data);
      if (resp_vld && resp_rdy && expq.size() > 0) begin
        last_resp = resp_rdata;
        n_resp++;
        void'(expq.pop_front());
        last_pop = cyc;
      end
      if (req_vld && req_rdy) begin
        model_req(req_wen, req_rwtyp, req_addr, req_wdata, m_err, m_data);
        n_acc++;
        if (m_err) err_m = 1'b1;
        if (!req_wen) begin
          ent.data = m_data;
          ent.acc  = cyc;
          expq.push_back(ent);
          last_load = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [2:0] typ, input logic [31:0] a, input logic [31:0] wd);
    bit acc;
    acc = 1'b0;
    req_vld = 1'b1; req_wen = wen; req_rwtyp = typ; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = req_rdy;
      tick();
    end
    req_vld = 1'b0;
    check_eq("accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic load_get(input logic [2:0] typ, input logic [31:0] a, output logic [31:0] d);
    int n0;
    bit got;
    n0 = n_resp;
    got = 1'b0;
    resp_rdy = 1'b1;
    issue(1'b0, typ, a, 32'b0);
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (n_resp > n0);
    end
    check_eq("load_resp", {31'b0, got}, 32'd1);
    d = last_resp;
  endtask

  logic [31:0] d;
  int          n0;

  initial begin
    for (int s = 0; s < NDUT; s++) begin
      rstn = 1'b0; sel = s; lat = lat_tab[s]; req_vld = 1'b0; resp_rdy = 1'b1;
      repeat (2) tick();
      rstn = 1'b1;
      @(negedge clk);
      check_eq("rst_rdy", {31'b0, req_rdy}, 32'd1);
      check_eq("rst_vld", {31'b0, resp_vld}, 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
      check_eq("rst_err", {31'b0, bus_err}, 32'd0);
      tick();

      for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);

      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      load_get(3'b010, 32'h10, d);
      check_eq("sw_lw", d, 32'hDEADBEEF);

      issue(1'b1, 3'b010, 32'h20, 32'h8081F0F0);
      load_get(3'b000, 32'h23, d); check_eq("lb", d, 32'hFFFFFF80);
      load_get(3'b100, 32'h23, d); check_eq("lbu", d, 32'h00000080);
      load_get(3'b001, 32'h20, d); check_eq("lh", d, 32'hFFFFF0F0);
      load_get(3'b101, 32'h22, d); check_eq("lhu", d, 32'h00008081);

      resp_rdy = 1'b0;
      n0 = n_acc;
      req_vld = 1'b1; req_wen = 1'b0; req_rwtyp = 3'b010;
      for (int k = 0; k < 20; k++) begin
        req_addr = 32'h40 + 32'(4 * k);
        tick();
      end
      @(negedge clk);
      check_eq("full_accepts", 32'(n_acc - n0), 32'(DEPTH));
      check_eq("full_rdy", {31'b0, req_rdy}, 32'd0);
      tick();
      resp_rdy = 1'b1;
      for (int i = 0; i < 60 && (n_acc - n0) < 5; i++) tick();
      req_vld = 1'b0;
      check_eq("fifth_accept", 32'(n_acc - n0), 32'd5);
      repeat (20) tick();
      check_eq("drain_bp", 32'(expq.size()), 32'd0);

      n0 = n_acc;
      req_vld = 1'b1; req_wen = 1'b0; req_rwtyp = 3'b010;
      for (int k = 0; k < 20; k++) begin
        req_addr = 32'h80 + 32'(4 * k);
        tick();
      end
      req_vld = 1'b0;
      check_eq("b2b_accepts", 32'(n_acc - n0), 32'(19 / lat + 1));
      repeat (20) tick();

      issue(1'b1, 3'b010, 32'h30, 32'h11223344);
      issue(1'b1, 3'b001, 32'h31, 32'h0000A5A5);
`ifdef DMEM_MISALIGN_CHK_EN
      check_eq("mis_err", {31'b0, bus_err}, 32'd1);
      load_get(3'b010, 32'h30, d); check_eq("mis_mem", d, 32'h11223344);
`else
      check_eq("mis_err", {31'b0, bus_err}, 32'd0);
      load_get(3'b010, 32'h30, d); check_eq("mis_mem", d, 32'h1122A5A5);
`endif
      load_get(3'b111, 32'h30, d);
      check_eq("ill_data", d, 32'd0);
      check_eq("ill_err", {31'b0, bus_err}, 32'd1);
      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      check_eq("err_cleared", {31'b0, bus_err}, 32'd0);

      if (lat > 1) begin
        n0 = n_resp;
        issue(1'b0, 3'b010, 32'h10, 32'b0);
        tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        repeat (10) tick();
        check_eq("rst_wait_noresp", 32'(n_resp - n0), 32'd0);
        check_eq("rst_wait_err", {31'b0, bus_err}, 32'd0);
        load_get(3'b010, 32'h10, d);
        check_eq("rst_wait_mem", d, 32'hDEADBEEF);
      end

      for (int i = 0; i < 800; i++) begin
        req_vld = ($urandom_range(0, 9) < 7);
        req_wen = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 19) == 0) begin
          req_rwtyp = 3'($urandom_range(0, 7));
        end else if (req_wen) begin
          req_rwtyp = 3'($urandom_range(0, 2));
        end else begin
          case ($urandom_range(0, 4))
            0: req_rwtyp = 3'b000;
            1: req_rwtyp = 3'b001;
            2: req_rwtyp = 3'b010;
            3: req_rwtyp = 3'b100;
            default: req_rwtyp = 3'b101;
          endcase
        end
        req_addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
        req_wdata = $urandom;
        resp_rdy  = ($urandom_range(0, 9) < 6);
        rstn      = ($urandom_range(0, 199) != 0);
        tick();
      end
      rstn = 1'b1; req_vld = 1'b0; resp_rdy = 1'b1;
      repeat (30) tick();
      check_eq("final_drain", 32'(expq.size()), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_dmem_resp.md
# core_dmem_resp

Bus-side data-memory responder for the LSU load/store request/response interface. It accepts LSU requests, performs byte/half/word stores into an internal word-organised SRAM, and returns sign- or zero-extended load data through an in-order response queue. Stores complete silently and produce no response beat. This matches the LSU contract that only loads consume a response.

## Interface
Parameters:
- `AW`, 10: word-address bits; memory holds 2^AW 32-bit words. Byte address bits [AW+1:2] index the array; higher bits are ignored, so accesses alias.
- `RESP_DEPTH`, 4: response queue entries, ≥2.
- `LATENCY`, 1: load cycles from accept to earliest `resp_vld`, range 1..15.

Ports:
- `clk`, in, 1: single clock.
- `rstn`, in, 1: synchronous, active-low reset.
- `req_vld`, in, 1: request valid.
- `req_wen`, in, 1: 1 = store, 0 = load.
- `req_rwtyp`, in, 3: RV32 func3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, taken from the low lanes.
- `req_rdy`, out, 1: request accept.
- `resp_vld`, out, 1: load data valid.
- `resp_rdata`, out, 32: extended load data.
- `resp_rdy`, in, 1: response accept.
- `bus_err`, out, 1: sticky error flag.

## Operation
- **Accept rule:** a request is accepted on any cycle with `req_vld && req_rdy`.
- **FSM states:**
  - IDLE: `req_rdy` = (queue occupancy + pending loads < RESP_DEPTH).
  - A load accept with LATENCY>1 moves IDLE→WAIT and loads the wait counter with LATENCY-1.
  - WAIT: `req_rdy`=0. The counter decrements each cycle; at 0 the read data is pushed to the queue and the FSM returns to IDLE.
  - With LATENCY=1 the push happens at the end of the accept cycle and the FSM stays in IDLE.
- **Stores:** always single-cycle and never enter WAIT. The write is committed at the accept edge.
  - sb writes lane `addr[1:0]`.
  - sh writes lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - sw writes all 4 lanes.
- **Loads:**
  - Lane selection is the same as for stores.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - The array read occurs at accept; the captured word is held through WAIT.
  - A store later in the stream cannot be accepted before the load's data is captured, so ordering is preserved.
- **Illegal rwtyp:** load 011/110/111, or store ≥011.
  - A load still produces a response with `resp_rdata`=0.
  - A store is dropped.
  - `bus_err` is set in both cases.
- **Response queue:** FIFO, in order.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
  - When full, no push is ever attempted, guaranteed by the `req_rdy` accounting.
  - `resp_rdata` is held stable while `resp_vld && !resp_rdy`.

## Timing
- **Reset values:** `req_rdy`=0 during the reset cycle and 1 afterwards (IDLE, empty). `resp_vld`=0, `resp_rdata`=0, `bus_err`=0.
- **Load latency:** accept in cycle T; `resp_vld` is earliest in T+LATENCY. A queued response appears in the cycle after the previous beat pops.
- **Throughput:**
  - LATENCY=1: one load per cycle while the queue has space, with back-to-back accepts.
  - LATENCY=n: one load per n cycles.
  - Stores: one per cycle.
- **Reset mid-operation:**
  - The pending WAIT load is discarded and the queue is emptied.
  - `bus_err` is cleared.
  - SRAM contents are not cleared.
- **Error flag:** `bus_err` sets in the cycle after the offending accept and stays set until reset.

## Configuration
- Macro `DMEM_MISALIGN_CHK_EN`.
- **Defined:** a misaligned access is flagged.
  - Misaligned means half access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
  - `bus_err` is set.
  - A misaligned store is dropped; a misaligned load returns 0 and still produces a response.
- **Undefined:** no check is made.
  - Half accesses force `addr[0]`=0; word accesses force `addr[1:0]`=0.
  - `bus_err` is driven only by illegal rwtyp.

## Test plan
- **Store word then load word:** sw 0xDEADBEEF @0x10, then lw @0x10 with `resp_rdy`=1 → single response 0xDEADBEEF at T+LATENCY; no response beat for the store.
- **Byte/half extension:** with word 0x8081F0F0 @0x20:
  - lb @0x23 → 0xFFFFFF80
  - lbu @0x23 → 0x00000080
  - lh @0x20 → 0xFFFFF0F0
  - lhu @0x22 → 0x00008081
- **Backpressure/full, LATENCY=1, RESP_DEPTH=4:**
  - Hold `resp_rdy`=0 and issue 5 back-to-back loads → exactly 4 accepted; `req_rdy`=0 after the 4th.
  - Release `resp_rdy` → 4 beats in order, then the 5th is accepted.
- **Simultaneous push/pop and wait states, LATENCY=3:**
  - Back-to-back loads issued.
  - `req_rdy` low for 2 cycles after each load accept.
  - A pop coinciding with a push leaves occupancy unchanged.
- **Errors:**
  - sh @0x31 with `DMEM_MISALIGN_CHK_EN` → `bus_err`=1 and memory unchanged.
  - Same access without the macro → halfword written @0x30.
  - Illegal load rwtyp 111 → response 0 and `bus_err`=1.
- **Reset mid-WAIT, LATENCY=4:** assert `rstn`=0 two cycles after a load accept → no response afterwards, `bus_err`=0, previously stored data still readable.
